ram_ctrl: RTL

//   Sequencer directly upstream of the 8x8 latch RAM. Accepts read/write requests on a

---
 rtl/ram_ctrl_pkg.sv | 39 +++
 rtl/ram_ctrl_if.sv | 44 ++++
 rtl/ram_ctrl_timer.sv | 44 ++++
 rtl/ram_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : ram_ctrl_pkg
//  Description: Shared definitions for the RAM sequencer: FSM state encoding,
//               RAM op encoding, default geometry/timing and a helper that
//               sizes the phase timer.
//  Revision   : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;

    // Same encoding as the RAM op pin.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_VSETUP  = 3'd4,
        ST_VSTROBE = 3'd5,
        ST_VHOLD   = 3'd6,
        ST_RESP    = 3'd7
    } state_e;

    // Timer is loaded with (cycles-1), so it only needs to hold max(a,b)-1.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : ram_ctrl_if
//  Description: Bundle of the request/response handshake and the RAM pin
//               bus. The slave modport is the controller; the master modport
//               is its environment (requester plus the RAM output).
//  Ports      : req_valid/req_ready/req_op/req_addr/req_wdata  request
//               rsp_valid/rsp_rdata/rsp_err                    response
//               ram_inp/ram_addr/ram_op/ram_sel/ram_outp       RAM pins
//  Revision   : 1.0 - initial release
// ============================================================================
interface ram_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [DATA_W-1:0] ram_inp;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_op;
    logic              ram_sel;
    logic [DATA_W-1:0] ram_outp;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, ram_outp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_inp, ram_addr, ram_op, ram_sel
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, ram_outp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_inp, ram_addr, ram_op, ram_sel
    );
endinterface
`default_nettype wire

// File: rtl/ram_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module     : ram_ctrl_timer
//  Description: Loadable down-counter used to time the SETUP and STROBE
//               phases. Load (cycles-1) on the edge entering a phase; done_o
//               is high in the last cycle of that phase.
//  Ports      : clk, rst          clock / synchronous active-high reset
//               load_i            load load_val_i on the next edge
//               load_val_i        value to load
//               done_o            counter has reached zero
//  Revision   : 1.0 - initial release
// ============================================================================
module ram_ctrl_timer #(
    parameter int CNT_W = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    output logic                  done_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : ram_ctrl
//  Description: Sequencer in front of an 8x8 latch RAM. Accepts one request
//               at a time on a valid/ready handshake and drives the RAM pins
//               through SETUP -> STROBE -> HOLD, then a one-cycle response.
//               All RAM pins are registered; addr/op/inp are only updated
//               while sel is low and outside HOLD.
//  Options    : WRITE_VERIFY_EN - writes are followed by a read-back of the
//               same address and rsp_err flags a data mismatch.
//  Ports      : clk, rst  clock / synchronous active-high reset
//               bus       ram_ctrl_if.slave (request, response, RAM pins)
//  Revision   : 1.0 - initial release
// ============================================================================
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC
) (
    input  wire logic clk,
    input  wire logic rst,
    ram_ctrl_if.slave bus
);
    localparam int               CNT_W     = timer_width(SETUP_CYC, STROBE_CYC);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);

    state_e            state_q;
    logic              sel_q;
    logic              op_q;
    logic              wr_q;      // original request was a write
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inp_q;
    logic [DATA_W-1:0] cap_q;     // RAM data sampled on the last strobe cycle
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
`ifdef WRITE_VERIFY_EN
    logic              rsp_err_q;
`endif

    logic              tmr_load_d;
    logic [CNT_W-1:0]  tmr_val_d;
    logic              tmr_done;

    // Timer loads coincide with the FSM edges that enter a timed phase.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = SETUP_LD;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = STROBE_LD;
                end
            end
`ifdef WRITE_VERIFY_EN
            ST_HOLD: begin
                if (wr_q) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = SETUP_LD;
                end
            end
            ST_VSETUP: begin
                if (tmr_done) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = STROBE_LD;
                end
            end
`endif
            default: ;
        endcase
    end

    ram_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            op_q        <= OP_READ;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            inp_q       <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        op_q    <= bus.req_op;
                        inp_q   <= bus.req_wdata;
                        wr_q    <= bus.req_op;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        sel_q   <= 1'b1;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        sel_q   <= 1'b0;
                        cap_q   <= bus.ram_outp;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
`ifdef WRITE_VERIFY_EN
                    if (wr_q) begin
                        // Read-back phase: only the op pin changes, sel is low.
                        op_q    <= OP_READ;
                        state_q <= ST_VSETUP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= cap_q;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end
`else
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= wr_q ? '0 : cap_q;
                    state_q     <= ST_RESP;
`endif
                end
`ifdef WRITE_VERIFY_EN
                ST_VSETUP: begin
                    if (tmr_done) begin
                        sel_q   <= 1'b1;
                        state_q <= ST_VSTROBE;
                    end
                end
                ST_VSTROBE: begin
                    if (tmr_done) begin
                        sel_q   <= 1'b0;
                        cap_q   <= bus.ram_outp;
                        state_q <= ST_VHOLD;
                    end
                end
                ST_VHOLD: begin
                    // inp_q still holds the data that was written.
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= cap_q;
                    rsp_err_q   <= (cap_q != inp_q);
                    state_q     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
`ifdef WRITE_VERIFY_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= ST_IDLE;
                end
                default: begin
                    sel_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef WRITE_VERIFY_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.ram_inp   = inp_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_op    = op_q;
    assign bus.ram_sel   = sel_q;
endmodule
`default_nettype wire
